// File: rtl/sr_pulse_ctrl.sv
// sr_pulse_ctrl: front end for an SR latch. Two raw push buttons (set, clear)
// are synchronised and debounced, and each press becomes one fixed-width
// pulse on s or r. After every pulse an all-low gap gives the latch time to
// settle. s and r are never high in the same cycle.
//
// Handshake: there is no valid/ready pair. A request is the single-cycle
// rising edge of a debounced button level. If the FSM is busy, the request
// is parked in a one-deep pending bit and served on the first IDLE cycle.
module sr_pulse_ctrl #(
    parameter int DB_CYCLES = 4,
    parameter int PULSE_W   = 2,
    parameter int GAP_W     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int PC_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int PC_W   = $clog2(PC_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [PC_W-1:0] PULSE_LAST = PC_W'(PULSE_W - 1);
    localparam logic [PC_W-1:0] GAP_LAST   = PC_W'(GAP_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        CLR_P = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Synchroniser flops
    logic r_set_meta, r_set_sync;
    logic r_clr_meta, r_clr_sync;

    // Debounce state
    logic [DB_W-1:0] r_set_cnt, r_clr_cnt;
    logic            r_set_db, r_clr_db;
    logic            r_set_db_prev, r_clr_db_prev;

    // Control state
    state_t          r_state;
    logic [PC_W-1:0] r_pcnt;
    logic            r_set_pend, r_clr_pend;
    logic            r_s, r_r, r_busy, r_conflict;

    // Combinational signals
    logic            w_set_req, w_clr_req;
    logic            w_set_eff, w_clr_eff;
    state_t          w_next_state;
    logic [PC_W-1:0] w_next_pcnt;
    logic            w_next_set_pend, w_next_clr_pend;
    logic            w_conflict;

    // Two-flop synchronisers bring both raw buttons into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_set_meta <= 1'b0;
            r_set_sync <= 1'b0;
            r_clr_meta <= 1'b0;
            r_clr_sync <= 1'b0;
        end else begin
            r_set_meta <= set_btn;
            r_set_sync <= r_set_meta;
            r_clr_meta <= clr_btn;
            r_clr_sync <= r_clr_meta;
        end
    end

    // Set debounce: the level flips only after DB_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_set_cnt <= '0;
            r_set_db  <= 1'b0;
        end else if (r_set_sync == r_set_db) begin
            r_set_cnt <= '0;
        end else if (r_set_cnt == DB_LAST) begin
            r_set_cnt <= '0;
            r_set_db  <= ~r_set_db;
        end else begin
            r_set_cnt <= r_set_cnt + DB_W'(1);
        end
    end

    // Clear debounce: same filter as the set channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_cnt <= '0;
            r_clr_db  <= 1'b0;
        end else if (r_clr_sync == r_clr_db) begin
            r_clr_cnt <= '0;
        end else if (r_clr_cnt == DB_LAST) begin
            r_clr_cnt <= '0;
            r_clr_db  <= ~r_clr_db;
        end else begin
            r_clr_cnt <= r_clr_cnt + DB_W'(1);
        end
    end

    // Delayed debounced levels for press (rising-edge) detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_set_db_prev <= 1'b0;
            r_clr_db_prev <= 1'b0;
        end else begin
            r_set_db_prev <= r_set_db;
            r_clr_db_prev <= r_clr_db;
        end
    end

    assign w_set_req = r_set_db & ~r_set_db_prev;
    assign w_clr_req = r_clr_db & ~r_clr_db_prev;
    assign w_set_eff = w_set_req | r_set_pend;
    assign w_clr_eff = w_clr_req | r_clr_pend;

    // Next-state, counter, pending-bit and conflict decode
    always_comb begin
        w_next_state    = r_state;
        w_next_pcnt     = '0;
        w_next_set_pend = r_set_pend | w_set_req;
        w_next_clr_pend = r_clr_pend | w_clr_req;
        w_conflict      = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_set_pend = r_set_pend;
                w_next_clr_pend = r_clr_pend;
                if (w_set_eff && w_clr_eff) begin
                    w_conflict      = 1'b1;
                    w_next_set_pend = 1'b0;
                    w_next_clr_pend = 1'b0;
                end else if (w_set_eff) begin
                    w_next_state    = SET_P;
                    w_next_set_pend = 1'b0;
                end else if (w_clr_eff) begin
                    w_next_state    = CLR_P;
                    w_next_clr_pend = 1'b0;
                end
            end
            SET_P, CLR_P: begin
                if (r_pcnt == PULSE_LAST) begin
                    w_next_state = GAP;
                end else begin
                    w_next_pcnt = r_pcnt + PC_W'(1);
                end
            end
            GAP: begin
                if (r_pcnt == GAP_LAST) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_pcnt = r_pcnt + PC_W'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, counter and pending registers; outputs registered from next-state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pcnt     <= '0;
            r_set_pend <= 1'b0;
            r_clr_pend <= 1'b0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pcnt     <= w_next_pcnt;
            r_set_pend <= w_next_set_pend;
            r_clr_pend <= w_next_clr_pend;
            r_s        <= (w_next_state == SET_P);
            r_r        <= (w_next_state == CLR_P);
            r_busy     <= (w_next_state != IDLE);
            r_conflict <= w_conflict;
        end
    end

    assign s        = r_s;
    assign r        = r_r;
    assign busy     = r_busy;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// Testbench for sr_pulse_ctrl: a per-cycle vector table for the default
// configuration, plus hand-written sequences for reset behaviour and an
// instance with DB_CYCLES=1, PULSE_W=3, GAP_W=2.
module tb_sr_pulse_ctrl;

  logic clk;
  logic rst;
  logic set_btn, clr_btn;
  logic s, r, busy, conflict;
  logic set2, clr2;
  logic s2, r2, busy2, conflict2;

  int total;
  int bad;

  typedef struct {
    logic set_in;
    logic clr_in;
    logic exp_s;
    logic exp_r;
    logic exp_busy;
    logic exp_conf;
  } vec_t;

  vec_t vecs[$];

  sr_pulse_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .set_btn  (set_btn),
    .clr_btn  (clr_btn),
    .s        (s),
    .r        (r),
    .busy     (busy),
    .conflict (conflict)
  );

  sr_pulse_ctrl #(
    .DB_CYCLES (1),
    .PULSE_W   (3),
    .GAP_W     (2)
  ) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .set_btn  (set2),
    .clr_btn  (clr2),
    .s        (s2),
    .r        (r2),
    .busy     (busy2),
    .conflict (conflict2)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic es, input logic er,
                           input logic eb, input logic ec);
    check({tag, " s"}, s, es);
    check({tag, " r"}, r, er);
    check({tag, " busy"}, busy, eb);
    check({tag, " conflict"}, conflict, ec);
    check({tag, " s&r"}, s & r, 1'b0);
  endtask

  task automatic add_run(input int n, input logic st, input logic cl, input logic es,
                         input logic er, input logic eb, input logic ec);
    vec_t v;
    v.set_in = st; v.clr_in = cl;
    v.exp_s = es; v.exp_r = er; v.exp_busy = eb; v.exp_conf = ec;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic one_press_set();
    // press at edge 1: s after edges 7,8, gap after 9, then held quiet
    add_run(6, 1, 0, 0, 0, 0, 0);
    add_run(2, 1, 0, 1, 0, 1, 0);
    add_run(1, 1, 0, 0, 0, 1, 0);
  endtask

  initial begin
    logic [19:0] bounce;
    total = 0;
    bad   = 0;
    rst     = 1'b1;
    set_btn = 1'b0;
    clr_btn = 1'b0;
    set2    = 1'b0;
    clr2    = 1'b0;

    // ---- reset held during random button activity ----
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_btn = 1'($urandom_range(0, 1));
      clr_btn = 1'($urandom_range(0, 1));
      set2    = 1'($urandom_range(0, 1));
      clr2    = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_all($sformatf("in_reset[%0d]", i), 0, 0, 0, 0);
      check("in_reset s2", s2 | r2 | busy2 | conflict2, 1'b0);
    end
    @(negedge clk);
    set_btn = 1'b0; clr_btn = 1'b0; set2 = 1'b0; clr2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("after_reset[%0d]", i), 0, 0, 0, 0);
    end

    // ---- vector table ----
    // clean press held 50 cycles, release 10, press again
    one_press_set();
    add_run(41, 1, 0, 0, 0, 0, 0);
    add_run(10, 0, 0, 0, 0, 0, 0);
    one_press_set();
    add_run(11, 1, 0, 0, 0, 0, 0);
    add_run(10, 0, 0, 0, 0, 0, 0);
    // simultaneous set and clear: one-cycle conflict, no pulse
    add_run(6, 1, 1, 0, 0, 0, 0);
    add_run(1, 1, 1, 0, 0, 0, 1);
    add_run(12, 1, 1, 0, 0, 0, 0);
    add_run(10, 0, 0, 0, 0, 0, 0);
    // clear arrives one cycle after set: queued behind the s pulse and gap
    add_run(1, 1, 0, 0, 0, 0, 0);
    add_run(5, 1, 1, 0, 0, 0, 0);
    add_run(2, 1, 1, 1, 0, 1, 0);
    add_run(1, 1, 1, 0, 0, 1, 0);
    add_run(1, 1, 1, 0, 0, 0, 0);
    add_run(2, 1, 1, 0, 1, 1, 0);
    add_run(1, 1, 1, 0, 0, 1, 0);
    add_run(7, 1, 1, 0, 0, 0, 0);
    add_run(10, 0, 0, 0, 0, 0, 0);
    // bounce: high runs of 1..3 cycles, then stable high
    bounce = 20'b1011_0011_1010_0110_1110;
    for (int i = 19; i >= 0; i--) add_run(1, bounce[i], 0, 0, 0, 0, 0);
    one_press_set();
    add_run(10, 1, 0, 0, 0, 0, 0);
    add_run(10, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      set_btn = vecs[i].set_in;
      clr_btn = vecs[i].clr_in;
      @(posedge clk);
      #1;
      check_all($sformatf("vec[%0d]", i), vecs[i].exp_s, vecs[i].exp_r,
                vecs[i].exp_busy, vecs[i].exp_conf);
    end

    // ---- reset asserted mid-SET_P ----
    @(negedge clk);
    set_btn = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("mid_pulse s before rst", s, 1'b1);
    #2;
    rst = 1'b1;
    set_btn = 1'b0;
    #1;
    check("mid_pulse s at rst", s, 1'b0);
    check("mid_pulse busy at rst", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("post_rst[%0d]", i), 0, 0, 0, 0);
    end

    // ---- DB_CYCLES=1, PULSE_W=3, GAP_W=2 instance ----
    @(negedge clk);
    set2 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("ovr s2[%0d]", i), s2, (i >= 3 && i <= 5));
      check($sformatf("ovr busy2[%0d]", i), busy2, (i >= 3 && i <= 7));
      check($sformatf("ovr r2[%0d]", i), r2, 1'b0);
      check($sformatf("ovr conflict2[%0d]", i), conflict2, 1'b0);
    end
    @(negedge clk);
    set2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
